// File: rtl/code_class_mapper_pkg.sv
// Shared types and defaults for the code-to-class mapper.
// Holds the table entry layout and the reset-time table contents.
package code_class_pkg;

    localparam int unsigned DEF_IN_W    = 3;
    localparam int unsigned DEF_CLASS_W = 2;
    localparam int unsigned DEF_CNT_W   = 16;
    // Entry class field is sized for the widest supported CLASS_W; unused upper bits stay zero.
    localparam int unsigned MAX_CLASS_W = 8;

    typedef struct packed {
        logic [MAX_CLASS_W-1:0] cls;
        logic                   en;
    } entry_t;

    function automatic entry_t reset_entry(input int unsigned i, input int unsigned class_w);
        entry_t e;
        e.cls = MAX_CLASS_W'(i % (32'd1 << class_w));
        e.en  = 1'b1;
        return e;
    endfunction

endpackage

// File: rtl/code_class_mapper_if.sv
// Code-in / class-out valid/ready bus of the mapper.
interface code_class_mapper_if
    import code_class_pkg::*;
#(
    parameter int unsigned IN_W    = DEF_IN_W,
    parameter int unsigned CLASS_W = DEF_CLASS_W
) ();

    logic               in_valid;
    logic               in_ready;
    logic [IN_W-1:0]    in_code;
    logic               out_valid;
    logic               out_ready;
    logic [CLASS_W-1:0] out_class;
    logic               out_miss;

    modport slave (
        input  in_valid, in_code, out_ready,
        output in_ready, out_valid, out_class, out_miss
    );

    modport master (
        output in_valid, in_code, out_ready,
        input  in_ready, out_valid, out_class, out_miss
    );

endinterface

// File: rtl/code_class_mapper_onehot_decoder.sv
// Binary code to one-hot vector, purely combinational.
module onehot_decoder #(
    parameter int unsigned IN_W = 3
) (
    input  logic [IN_W-1:0]       code,
    output logic [(1<<IN_W)-1:0]  onehot
);

    always_comb begin
        onehot       = '0;
        onehot[code] = 1'b1;
    end

endmodule

// File: rtl/code_class_mapper.sv
// Programmable code-to-class mapper: 2-stage valid/ready pipeline
// (one-hot decode, class encode) with saturating per-class hit counters.
module code_class_mapper
    import code_class_pkg::*;
#(
    parameter int unsigned IN_W    = DEF_IN_W,
    parameter int unsigned CLASS_W = DEF_CLASS_W,
    parameter int unsigned CNT_W   = DEF_CNT_W
) (
    input  logic                clk,
    input  logic                rst,
    code_class_mapper_if.slave  bus,
    input  logic                cfg_we,
    input  logic [IN_W-1:0]     cfg_addr,
    input  logic [CLASS_W-1:0]  cfg_class,
    input  logic                cfg_en,
    input  logic                cnt_clr,
    input  logic [CLASS_W-1:0]  cnt_sel,
    output logic [CNT_W-1:0]    cnt_val
);

    localparam int unsigned DEPTH = 1 << IN_W;
    localparam int unsigned NCLS  = 1 << CLASS_W;

    entry_t               tbl [DEPTH];
    logic [DEPTH-1:0]     dec;
    logic [DEPTH-1:0]     s1_oh;
    logic                 s1_valid;
    logic                 ov_q;
    logic [CLASS_W-1:0]   oc_q;
    logic                 om_q;
    logic [NCLS-1:0]      hit;
    logic [CLASS_W-1:0]   enc_class;
    logic                 s2_adv;
    logic                 in_rdy;
    logic                 in_fire;
    logic                 out_fire;
    logic [CNT_W-1:0]     cnt [NCLS];

    onehot_decoder #(.IN_W(IN_W)) u_dec (
        .code   (bus.in_code),
        .onehot (dec)
    );

    assign s2_adv        = !ov_q || bus.out_ready;
    assign in_rdy        = !rst && (!s1_valid || s2_adv);
    assign in_fire       = bus.in_valid && in_rdy;
    assign out_fire      = ov_q && !rst && bus.out_ready;
    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = ov_q && !rst;
    assign bus.out_class = oc_q;
    assign bus.out_miss  = om_q;
    assign cnt_val       = rst ? '0 : cnt[cnt_sel];

    // Membership OR per class; at most one class can hit since the vector is one-hot.
    always_comb begin
        hit       = '0;
        enc_class = '0;
        for (int unsigned c = 0; c < NCLS; c++) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (s1_oh[i] && tbl[i].en && tbl[i].cls == MAX_CLASS_W'(c))
                    hit[c] = 1'b1;
            end
            if (hit[c])
                enc_class = enc_class | CLASS_W'(c);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_oh    <= '0;
            ov_q     <= 1'b0;
            oc_q     <= '0;
            om_q     <= 1'b0;
        end else begin
            if (s2_adv) begin
                ov_q <= s1_valid;
                if (s1_valid) begin
                    oc_q <= enc_class;
                    om_q <= ~|hit;
                end
            end
            if (in_fire) begin
                s1_valid <= 1'b1;
                s1_oh    <= dec;
            end else if (s2_adv) begin
                s1_valid <= 1'b0;
            end
        end
    end

    // The write lands at the edge, so a same-cycle stage-2 lookup sees the old entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++)
                tbl[i] <= reset_entry(i, CLASS_W);
        end else if (cfg_we) begin
            tbl[cfg_addr].cls <= MAX_CLASS_W'(cfg_class);
            tbl[cfg_addr].en  <= cfg_en;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            for (int unsigned c = 0; c < NCLS; c++)
                cnt[c] <= '0;
        end else if (out_fire && !om_q && cnt[oc_q] != '1) begin
            cnt[oc_q] <= cnt[oc_q] + CNT_W'(1);
        end
    end

endmodule

// File: doc/code_class_mapper.md
# code_class_mapper

- Maps an `IN_W`-bit input code to a `CLASS_W`-bit class id through a run-time programmable table.
- Each table entry holds a class id and an enable bit; codes whose entry is disabled are flagged as misses.
- Built as a 2-stage valid/ready pipeline: one-hot decode, then class encode.
- Keeps a saturating hit counter per class and sits between the code source and the downstream class consumers.

## Interface
- `IN_W`, default 3: input code width; table depth = 2**IN_W.
- `CLASS_W`, default 2: class id width; number of classes = 2**CLASS_W.
- `CNT_W`, default 16: per-class hit counter width.
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: input code valid.
- `in_ready` out 1: stage 1 can accept.
- `in_code` in `IN_W`: code to classify.
- `out_valid` out 1: result valid.
- `out_ready` in 1: downstream accepts.
- `out_class` out `CLASS_W`: mapped class id.
- `out_miss` out 1: the entry was disabled.
- `cfg_we` in 1: table write strobe.
- `cfg_addr` in `IN_W`: table entry to write.
- `cfg_class` in `CLASS_W`: class id to store.
- `cfg_en` in 1: entry enable to store.
- `cnt_clr` in 1: clear all hit counters.
- `cnt_sel` in `CLASS_W`: counter read select.
- `cnt_val` out `CNT_W`: combinational read of counter `cnt_sel`.

## Operation
- **Reset contents.**
  - Entry i is loaded with class = i mod 2**CLASS_W and enable = 1.
  - All counters are cleared to 0.
  - Pipeline valids are cleared.
- **Stage 1 (decode).**
  - Captures `in_code` as a one-hot vector of width 2**IN_W when the stage-1 handshake (`in_valid` && `in_ready`) occurs.
- **Stage 2 (encode).**
  - OR-reduces the one-hot vector against each class's membership mask, derived from the table: class c's mask = entries with class == c and en == 1.
  - Result registers into `out_class`.
  - `out_miss` = 1 when no mask matches; `out_class` is then 0.
  - A zero or multi-hot one-hot vector cannot occur by construction; no priority logic beyond the membership OR is needed.
- **Table lookup timing.**
  - Stage 2 reads the table at the cycle the data moves from stage 1 to stage 2.
  - A `cfg_we` in that same cycle is not visible; the old entry is used and the write lands at the clock edge.
- **Counters.**
  - On each output handshake (`out_valid` && `out_ready`) with `out_miss` = 0, `cnt[out_class]` increments.
  - Counters saturate at 2**CNT_W-1; they never wrap.
  - Misses are not counted.
- **Counter clear.**
  - `cnt_clr` zeroes all counters and has priority over a same-cycle increment.
  - A same-cycle increment is lost.
- **Reset mid-operation.**
  - Discards both in-flight codes; no counter is updated.
  - The table returns to its reset contents, and programmed entries are lost.

## Timing
- **Latency:** 2 cycles from input handshake to `out_valid`, with no stall.
- **Throughput:** 1 code/cycle.
- **Stall rule.**
  - Stage 2 advances when `!out_valid || out_ready`.
  - `in_ready` = `!s1_valid || stage2_advance`; this is a combinational path from `out_ready` to `in_ready`.
  - With `out_ready` = 0 and both stages full, `in_ready` = 0; data is held stable and no code is dropped or duplicated.
- **Output stability.** `out_valid`, `out_class` and `out_miss` stay stable while `out_valid` && !`out_ready`.
- **Outputs under reset.**
  - While `rst` = 1: `out_valid` = 0 and `in_ready` = 0.
  - `out_class` and `out_miss` reset to 0.
  - `cnt_val` reads 0.
  - `in_ready` rises in the first cycle after `rst` deasserts.
- **Config writes.** Accepted in any cycle except under reset, independent of the handshakes; effective for the stage-2 lookup 1 cycle later.

## Structure
- **Shared package `code_class_pkg`:**
  - default parameter values;
  - the entry struct type (class, en);
  - the function giving the reset table entry for index i.
- **Sub-module `onehot_decoder`:** parametric `IN_W` → one-hot, combinational; instantiated in front of the stage-1 register.
- Table, class encoder, counters and handshake logic live in the top module.

## Test plan
- **Reset table, no stall.** IN_W=3, CLASS_W=2. Stream codes 0..7 with `out_ready`=1 → classes 0,1,2,3,0,1,2,3 on cycles 2..9, `out_miss`=0; `cnt_val` = 2 for every class.
- **Programmed grouping.** Program 0→3, 1→0, 2→3, 3→1, 4→1, 5→2, 6→2, 7→1, then stream 0..7 → 3,0,3,1,1,2,2,1; `cnt[1]`=3.
- **Miss.** Write entry 5 with en=0, send 5 → `out_miss`=1, `out_class`=0, no counter changes.
- **Backpressure.** Hold `out_ready`=0 for 4 cycles while sending 3 codes → `in_ready` falls after 2 accepts, the output is held stable, and all 3 results appear in order after release.
- **Write-vs-lookup collision.** Rewrite entry 2 to class 0 in the same cycle code 2 moves to stage 2 → old class 2 is output; the next code 2 yields 0.
- **Saturation, clear, mid-flight reset.**
  - CNT_W=2: 5 hits on class 1 → `cnt_val`=3.
  - `cnt_clr` together with a hit → 0.
  - `rst` pulsed with 2 codes in flight → no outputs, counters 0, table at reset contents.
